// File: rtl/readout_sequencer_pkg.sv
// Shared definitions for the readout sequencer: FSM state encoding and the
// frame-length helper.
package readout_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_LATCH = 2'd1;
  localparam state_t ST_LOAD  = 2'd2;
  localparam state_t ST_SHIFT = 2'd3;

  // Cycles with busy high: one LATCH cycle, then a LOAD plus COUNT_W shifts per channel.
  function automatic int unsigned frame_len(input int unsigned num_ch,
                                            input int unsigned count_w);
    return 1 + num_ch * (1 + count_w);
  endfunction

endpackage

// File: rtl/readout_sequencer_if.sv
// Counter-bank and serial-pin bundle between the readout sequencer (master)
// and the counter bank / pad ring (slave).
interface readout_sequencer_if #(
  parameter int COUNT_W = 16,
  parameter int ADDR_W  = 4
);
  logic [ADDR_W-1:0]  addr;
  logic               latch;
  logic [COUNT_W-1:0] cnt_data;
  logic               sl_out;
  logic               serial_out;

  modport master (
    output addr,
    output latch,
    output sl_out,
    output serial_out,
    input  cnt_data
  );

  modport slave (
    input  addr,
    input  latch,
    input  sl_out,
    input  serial_out,
    output cnt_data
  );
endinterface

// File: rtl/readout_sequencer_rtc_edge_sync.sv
// Two-flop synchroniser for the asynchronous RTC pin with a third flop for
// rising-edge detection.
module rtc_edge_sync (
  input  logic clk,
  input  logic reset,
  input  logic async_in,
  output logic rise
);
  // [0] = first sync stage, [1] = second sync stage, [2] = edge-detect history
  logic [2:0] sync_q;
  logic [2:0] sync_d;

  always_comb begin
    sync_d = {sync_q[1:0], async_in};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= 3'b000;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign rise = sync_q[1] & ~sync_q[2];

endmodule

// File: rtl/readout_sequencer.sv
// Readout frame scheduler: on each synchronised RTC tick, latches the counter
// bank and shifts every channel count out MSB-first with a load marker.
module readout_sequencer
  import readout_pkg::*;
#(
  parameter int NUM_CH  = 8,
  parameter int COUNT_W = 16,
  parameter int ADDR_W  = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 ena,
  input  logic                 rtc,
  input  logic                 ovf_clr,
  readout_sequencer_if.master  bus,
  output logic                 busy,
  output logic                 frame_done,
  output logic                 ovf_rtc
);

  localparam int                BIT_W   = $clog2(COUNT_W);
  localparam logic [ADDR_W-1:0] LAST_CH = ADDR_W'(NUM_CH - 1);
  localparam logic [BIT_W-1:0]  BIT_MAX = BIT_W'(COUNT_W - 1);

  if (NUM_CH < 2 || NUM_CH > 16 || COUNT_W < 2 || (2 ** ADDR_W) < NUM_CH) begin : g_bad_param
    $error("readout_sequencer: illegal NUM_CH/COUNT_W/ADDR_W combination");
  end

  state_t             state_q,      state_d;
  logic [ADDR_W-1:0]  addr_q,       addr_d;
  logic [BIT_W-1:0]   bit_q,        bit_d;
  logic [COUNT_W-1:0] sr_q,         sr_d;
  logic               latch_q,      latch_d;
  logic               sl_out_q,     sl_out_d;
  logic               serial_q,     serial_d;
  logic               busy_q,       busy_d;
  logic               frame_done_q, frame_done_d;
  logic               ovf_q,        ovf_d;

  logic rtc_rise;
  logic last_bit;
  logic last_ch;
  logic ovf_set;

  rtc_edge_sync u_rtc_sync (
    .clk      (clk),
    .reset    (reset),
    .async_in (rtc),
    .rise     (rtc_rise)
  );

  assign last_bit = (bit_q == '0);
  assign last_ch  = (addr_q == LAST_CH);

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    bit_d        = bit_q;
    sr_d         = sr_q;
    frame_done_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        addr_d = '0;
        // The frame_done cycle still counts as part of the old frame.
        if (rtc_rise && ena && !frame_done_q) begin
          state_d = ST_LATCH;
        end
      end
      ST_LATCH: begin
        state_d = ST_LOAD;
      end
      ST_LOAD: begin
        sr_d    = bus.cnt_data;
        bit_d   = BIT_MAX;
        state_d = ST_SHIFT;
      end
      default: begin
        sr_d  = sr_q << 1;
        bit_d = bit_q - 1'b1;
        if (last_bit) begin
          if (last_ch) begin
            addr_d       = '0;
            frame_done_d = 1'b1;
            state_d      = ST_IDLE;
          end else begin
            addr_d  = addr_q + 1'b1;
            state_d = ST_LOAD;
          end
        end
      end
    endcase
  end

  // Outputs are registered from the next state so they are glitch-free pins.
  always_comb begin
    latch_d  = (state_d == ST_LATCH);
    sl_out_d = (state_d == ST_LOAD);
    busy_d   = (state_d != ST_IDLE);
    serial_d = (state_d == ST_SHIFT) ? sr_d[COUNT_W-1] : 1'b0;
  end

  // A tick is dropped whenever a frame owns the sequencer, including frame_done.
  always_comb begin
    ovf_set = rtc_rise && ((state_q != ST_IDLE) || frame_done_q);
    ovf_d   = ovf_set | (ovf_q & ~ovf_clr);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      addr_q       <= '0;
      bit_q        <= '0;
      latch_q      <= 1'b0;
      sl_out_q     <= 1'b0;
      serial_q     <= 1'b0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      ovf_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      bit_q        <= bit_d;
      latch_q      <= latch_d;
      sl_out_q     <= sl_out_d;
      serial_q     <= serial_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
      ovf_q        <= ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    sr_q <= sr_d;
  end

  assign bus.addr       = addr_q;
  assign bus.latch      = latch_q;
  assign bus.sl_out     = sl_out_q;
  assign bus.serial_out = serial_q;
  assign busy           = busy_q;
  assign frame_done     = frame_done_q;
  assign ovf_rtc        = ovf_q;

endmodule

// File: tb/tb_readout_sequencer.sv
// Scoreboard bench for readout_sequencer: a default instance and a minimal
// NUM_CH=2/COUNT_W=2 instance, checked by negedge monitors against queues.
module tb_readout_sequencer;
  import readout_pkg::*;

  localparam int CW  = 16;
  localparam int NCH = 8;

  typedef struct {
    int          addr;
    logic [15:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic reset, ena, rtc, ovf_clr;
  logic busy, frame_done, ovf_rtc;
  logic rtc_b;
  logic busy_b, frame_done_b, ovf_rtc_b;
  logic [15:0] base;

  int cyc = 0;
  int n_vec = 0;
  int n_err = 0;

  exp_t exp_q[$];
  exp_t exp_qb[$];

  readout_sequencer_if #(.COUNT_W(16), .ADDR_W(4)) bus ();
  readout_sequencer_if #(.COUNT_W(2),  .ADDR_W(1)) bus_b ();

  assign bus.cnt_data   = base + 16'(bus.addr);
  assign bus_b.cnt_data = 2'b10;

  readout_sequencer #(.NUM_CH(8), .COUNT_W(16), .ADDR_W(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .ena        (ena),
    .rtc        (rtc),
    .ovf_clr    (ovf_clr),
    .bus        (bus),
    .busy       (busy),
    .frame_done (frame_done),
    .ovf_rtc    (ovf_rtc)
  );

  readout_sequencer #(.NUM_CH(2), .COUNT_W(2), .ADDR_W(1)) dut_b (
    .clk        (clk),
    .reset      (reset),
    .ena        (1'b1),
    .rtc        (rtc_b),
    .ovf_clr    (1'b0),
    .bus        (bus_b),
    .busy       (busy_b),
    .frame_done (frame_done_b),
    .ovf_rtc    (ovf_rtc_b)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, got time %0t required < 300000", $time);
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- monitor: default instance ----------------
  logic [CW-1:0] word;
  int nb, cur_addr, latch_t, last_sl, n_sl_frame;
  int n_latch = 0;
  int n_sl = 0;
  bit collecting = 0;

  always @(negedge clk) begin
    if (reset) begin
      collecting = 0;
    end else begin
      if (bus.latch) begin
        n_latch++;
        latch_t    = cyc;
        n_sl_frame = 0;
      end
      if (collecting) begin
        word = {word[CW-2:0], bus.serial_out};
        nb++;
        chk("addr_stable", 32'(bus.addr), 32'(cur_addr));
        if (nb == CW) begin
          collecting = 0;
          if (exp_q.size() == 0) begin
            chk("unexpected_channel", 32'(1), 32'(0));
          end else begin
            exp_t e;
            e = exp_q.pop_front();
            chk("ch_addr", 32'(cur_addr), 32'(e.addr));
            chk("ch_data", 32'(word), 32'(e.data));
          end
        end
      end
      if (bus.sl_out) begin
        n_sl++;
        if (n_sl_frame > 0) chk("sl_spacing", 32'(cyc - last_sl), 32'(17));
        else                chk("latch_to_load", 32'(cyc - latch_t), 32'(1));
        n_sl_frame++;
        last_sl = cyc;
        chk("load_serial_low", 32'(bus.serial_out), 32'(0));
        collecting = 1;
        nb         = 0;
        cur_addr   = int'(bus.addr);
        word       = '0;
      end
      if (frame_done) begin
        chk("frame_len", 32'(cyc - latch_t), 32'(137));
        chk("done_addr0", 32'(bus.addr), 32'(0));
        chk("done_busy0", 32'(busy), 32'(0));
        chk("loads_per_frame", 32'(n_sl_frame), 32'(NCH));
      end
    end
  end

  // ---------------- monitor: boundary instance ----------------
  logic [1:0] word_b;
  int nb_b, cur_b, latch_tb;
  bit col_b = 0;

  always @(negedge clk) begin
    if (reset) begin
      col_b = 0;
    end else begin
      if (bus_b.latch) latch_tb = cyc;
      if (col_b) begin
        word_b = {word_b[0], bus_b.serial_out};
        nb_b++;
        if (nb_b == 2) begin
          col_b = 0;
          if (exp_qb.size() == 0) begin
            chk("b_unexpected_channel", 32'(1), 32'(0));
          end else begin
            exp_t e;
            e = exp_qb.pop_front();
            chk("b_ch_addr", 32'(cur_b), 32'(e.addr));
            chk("b_ch_data", 32'(word_b), 32'(e.data));
          end
        end
      end
      if (bus_b.sl_out) begin
        col_b = 1;
        nb_b  = 0;
        cur_b = int'(bus_b.addr);
      end
      if (frame_done_b) begin
        chk("b_frame_len", 32'(cyc - latch_tb), 32'(7));
        chk("b_addr_wrap", 32'(bus_b.addr), 32'(0));
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_rtc(input int n);
    rtc = 1'b1;
    step(n);
    rtc = 1'b0;
  endtask

  task automatic push_frame(input logic [15:0] b);
    for (int a = 0; a < NCH; a++) begin
      exp_t e;
      e.addr = a;
      e.data = b + 16'(a);
      exp_q.push_back(e);
    end
  endtask

  function automatic logic cond(input int which, input int val);
    case (which)
      0:       return bus.latch;
      1:       return frame_done;
      2:       return bus.sl_out && (int'(bus.addr) == val);
      default: return frame_done_b;
    endcase
  endfunction

  task automatic wait_for(input string name, input int which, input int val, input int budget);
    int k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!cond(which, val) && k < budget);
    chk({"wait_", name}, 32'(cond(which, val)), 32'(1));
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_addr"},       32'(bus.addr),       32'(0));
    chk({tag, "_latch"},      32'(bus.latch),      32'(0));
    chk({tag, "_sl_out"},     32'(bus.sl_out),     32'(0));
    chk({tag, "_serial"},     32'(bus.serial_out), 32'(0));
    chk({tag, "_busy"},       32'(busy),           32'(0));
    chk({tag, "_frame_done"}, 32'(frame_done),     32'(0));
    chk({tag, "_ovf"},        32'(ovf_rtc),        32'(0));
  endtask

  initial begin
    int fl, l0, s0, t0;
    fl      = int'(frame_len(NCH, CW)) + 20;
    reset   = 1'b1;
    ena     = 1'b1;
    rtc     = 1'b0;
    ovf_clr = 1'b0;
    rtc_b   = 1'b0;
    base    = 16'hA500;

    // reset state
    step(3);
    @(negedge clk);
    check_idle("reset");
    step(1);
    reset = 1'b0;
    step(2);

    // single frame, defaults
    l0 = n_latch; s0 = n_sl;
    base = 16'hA500;
    push_frame(base);
    pulse_rtc(3);
    wait_for("latch_single", 0, 0, 10);
    wait_for("done_single", 1, 0, fl);
    chk("single_latch_once", 32'(n_latch - l0), 32'(1));
    chk("single_sl_count", 32'(n_sl - s0), 32'(8));
    step(1);
    chk("single_no_ovf", 32'(ovf_rtc), 32'(0));

    // overlapping tick at channel 3, then clear
    l0 = n_latch;
    base = 16'h3C00;
    push_frame(base);
    pulse_rtc(3);
    wait_for("ovl_ch3", 2, 3, fl);
    step(2);
    pulse_rtc(3);
    wait_for("done_ovl", 1, 0, fl);
    chk("ovl_single_latch", 32'(n_latch - l0), 32'(1));
    step(1);
    chk("ovl_ovf_set", 32'(ovf_rtc), 32'(1));
    ovf_clr = 1'b1;
    step(1);
    ovf_clr = 1'b0;
    @(negedge clk);
    chk("ovl_ovf_cleared", 32'(ovf_rtc), 32'(0));

    // dropped tick coincident with ovf_clr: set wins
    step(1);
    base = 16'h0FF0;
    push_frame(base);
    pulse_rtc(3);
    wait_for("coin_ch1", 2, 1, fl);
    step(2);
    pulse_rtc(3);
    @(negedge clk);
    chk("coin_ovf_pre", 32'(ovf_rtc), 32'(1));
    wait_for("coin_ch3", 2, 3, fl);
    step(1);
    rtc = 1'b1;
    step(2);
    ovf_clr = 1'b1;
    step(1);
    ovf_clr = 1'b0;
    rtc = 1'b0;
    @(negedge clk);
    chk("coin_set_wins", 32'(ovf_rtc), 32'(1));
    wait_for("done_coin", 1, 0, fl);
    step(1);
    ovf_clr = 1'b1;
    step(1);
    ovf_clr = 1'b0;

    // ena gating in IDLE
    ena = 1'b0;
    l0 = n_latch;
    pulse_rtc(3);
    step(10);
    @(negedge clk);
    chk("ena0_no_latch", 32'(n_latch - l0), 32'(0));
    chk("ena0_no_ovf", 32'(ovf_rtc), 32'(0));
    chk("ena0_idle", 32'(busy), 32'(0));

    // ena dropped mid-frame
    step(1);
    ena = 1'b1;
    base = 16'hC3F8;
    push_frame(base);
    pulse_rtc(3);
    wait_for("ena_ch2", 2, 2, fl);
    step(1);
    ena = 1'b0;
    wait_for("done_ena_drop", 1, 0, fl);
    step(1);
    ena = 1'b1;
    chk("ena_drop_no_ovf", 32'(ovf_rtc), 32'(0));

    // reset during a channel-4 shift
    base = 16'h8001;
    push_frame(base);
    pulse_rtc(3);
    wait_for("rst_ch4", 2, 4, fl);
    step(5);
    reset = 1'b1;
    exp_q.delete();
    step(1);
    reset = 1'b0;
    @(negedge clk);
    check_idle("rst_mid");
    step(2);
    l0 = n_latch; s0 = n_sl;
    base = 16'h7E10;
    push_frame(base);
    pulse_rtc(3);
    wait_for("latch_after_rst", 0, 0, 10);
    wait_for("done_after_rst", 1, 0, fl);
    chk("after_rst_sl_count", 32'(n_sl - s0), 32'(8));

    // back-to-back: tick landing on frame_done is dropped
    step(2);
    base = 16'h4B00;
    push_frame(base);
    pulse_rtc(3);
    wait_for("latch_b2b_x", 0, 0, 10);
    step(135);
    rtc = 1'b1;
    step(1);
    rtc = 1'b0;
    l0 = n_latch;
    wait_for("done_b2b_x", 1, 0, fl);
    step(6);
    @(negedge clk);
    chk("b2b_dropped_no_latch", 32'(n_latch - l0), 32'(0));
    chk("b2b_dropped_ovf", 32'(ovf_rtc), 32'(1));
    chk("b2b_dropped_idle", 32'(busy), 32'(0));
    step(1);
    ovf_clr = 1'b1;
    step(1);
    ovf_clr = 1'b0;

    // back-to-back: tick one cycle after frame_done is accepted
    base = 16'h2D40;
    push_frame(base);
    pulse_rtc(3);
    wait_for("latch_b2b_y", 0, 0, 10);
    step(136);
    rtc = 1'b1;
    step(1);
    rtc = 1'b0;
    push_frame(base);
    wait_for("done_b2b_y", 1, 0, fl);
    t0 = cyc;
    l0 = n_latch;
    wait_for("latch_b2b_z", 0, 0, 10);
    chk("b2b_latch_delay", 32'(cyc - t0), 32'(2));
    wait_for("done_b2b_z", 1, 0, fl);
    chk("b2b_accepted_latch", 32'(n_latch - l0), 32'(1));
    step(1);
    chk("b2b_accepted_no_ovf", 32'(ovf_rtc), 32'(0));

    // boundary instance: NUM_CH=2, COUNT_W=2
    step(2);
    begin
      exp_t e;
      e.addr = 0; e.data = 16'h2; exp_qb.push_back(e);
      e.addr = 1; e.data = 16'h2; exp_qb.push_back(e);
    end
    rtc_b = 1'b1;
    step(3);
    rtc_b = 1'b0;
    wait_for("done_boundary", 3, 0, 30);
    step(2);

    chk("exp_queue_drained", 32'(exp_q.size()), 32'(0));
    chk("b_exp_queue_drained", 32'(exp_qb.size()), 32'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/readout_sequencer.md
Name: readout_sequencer

Overview:
- Scheduler for the multi-channel impulse counter bank.
- On each RTC tick it sequences one readout frame:
  - issues a snapshot strobe to the counter bank;
  - walks the channel address 0..NUM_CH-1;
  - loads each selected count into an internal shift register;
  - shifts the count out MSB-first on a single serial pin, with a shift/load marker.
- Sits between the RTC/counter bank and the chip's serial output pins.
- Flags RTC ticks that arrive while a frame is still in progress.

Parameters:
- NUM_CH, 8, number of counter channels read per frame (2..16).
- COUNT_W, 16, width of each channel count in bits (>=2).
- ADDR_W, 4, channel address width; must satisfy 2**ADDR_W >= NUM_CH.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- ena  in  1  when low, new frames are not started; a frame already running completes.
- rtc  in  1  RTC tick pin, asynchronous to clk; synchronised internally.
- cnt_data  in  COUNT_W  snapshot count of the channel selected by addr.
- ovf_clr  in  1  single-cycle pulse that clears ovf_rtc.
- addr  out  ADDR_W  channel select to the counter bank.
- latch  out  1  one-cycle pulse: counter bank copies live counts to snapshot registers and clears the live counts.
- sl_out  out  1  high for the load cycle of each channel (shift/load marker).
- serial_out  out  1  serial data bit, MSB-first.
- busy  out  1  high from the LATCH cycle through the last shift cycle of a frame.
- frame_done  out  1  one-cycle pulse after the last bit of the last channel.
- ovf_rtc  out  1  sticky flag: an RTC tick was dropped because a frame was busy.

Behaviour:
- Reset: synchronous, active-high. On reset, every output is 0, the FSM goes to IDLE, and the synchroniser flops are cleared. A reset asserted mid-frame aborts the frame; all outputs are 0 from the next edge onward.
- RTC synchroniser: rtc passes through two flops, plus a third flop for edge detection. rtc_rise = sync2 & ~sync3.
  - rtc first sampled high at edge N → rtc_rise valid after edge N+1 → FSM enters LATCH at edge N+2.
  - An rtc pulse shorter than one clk period is not guaranteed to be seen.
- FSM states: IDLE, LATCH, LOAD, SHIFT.
- IDLE:
  - addr = 0, serial_out = 0.
  - On rtc_rise & ena → LATCH.
  - On rtc_rise & !ena → stay in IDLE; the tick is ignored and ovf_rtc is not set.
- LATCH (1 cycle): latch = 1, busy = 1 → LOAD.
- LOAD (1 cycle):
  - sl_out = 1, serial_out = 0.
  - The shift register captures cnt_data for the current addr at the end of the cycle.
  - Bit counter := COUNT_W-1.
  - → SHIFT.
- SHIFT (COUNT_W cycles):
  - serial_out = shift register MSB, registered so it is glitch-free.
  - Each cycle the register shifts left with zero fill and the bit counter decrements.
  - After the cycle in which the bit counter is 0:
    - if addr == NUM_CH-1: addr := 0, frame_done pulses for 1 cycle (coincident with the IDLE entry cycle), busy drops, → IDLE;
    - else: addr := addr+1, → LOAD.
- Frame length: exactly 1 + NUM_CH*(1+COUNT_W) cycles with busy high (137 for the defaults). A new frame can start no earlier than the cycle after frame_done.
- Dropped ticks: rtc_rise while busy, or on the frame_done cycle, sets ovf_rtc and does not restart or extend the frame.
- ovf_clr clears ovf_rtc. If a set and a clear occur in the same cycle, set wins.
- addr is stable throughout each LOAD and SHIFT window. The counter bank must present cnt_data combinationally, valid within the LOAD cycle.
- ena falling mid-frame has no effect until the FSM returns to IDLE.

Decomposition:
- Package readout_pkg holds:
  - FSM state encoding: IDLE=2'd0, LATCH=2'd1, LOAD=2'd2, SHIFT=2'd3;
  - a function computing the frame-length constant, used by the bench.
- One sub-module, rtc_edge_sync (2-flop synchroniser plus rising-edge detect, synchronous reset), instantiated once.
- The FSM, address counter, bit counter, shift register and ovf logic live in readout_sequencer.

Test Plan:
- Single frame, defaults. cnt_data = 16'hA500+addr; pulse rtc high for 3 cycles.
  - latch pulses once.
  - sl_out pulses 8 times, 17 cycles apart.
  - Channel 0 bits: 1010_0101_0000_0000. Channel 7 ends ...0111.
  - frame_done arrives 137 cycles after latch; addr returns to 0.
- Overlapping tick: second rtc pulse mid-frame at channel 3.
  - Frame completes unchanged and ovf_rtc = 1.
  - ovf_clr pulse → ovf_rtc = 0.
  - ovf_clr coincident with another dropped tick → ovf_rtc stays 1.
- ena gating:
  - ena = 0 with rtc pulse in IDLE → no latch, ovf_rtc stays 0.
  - ena dropped at channel 2 mid-frame → frame still finishes with frame_done.
- Reset mid-shift: reset asserted during a channel-4 SHIFT cycle.
  - Next cycle: all outputs 0, busy = 0.
  - A fresh rtc pulse then produces a full, correct 137-cycle frame.
- Boundary parameters: NUM_CH=2, COUNT_W=2, cnt_data=2'b10 for both channels.
  - Frame length is 7 cycles; serial_out = 1,0 per channel.
  - addr wraps from 1 to 0.
- Back-to-back: rtc rise timed so rtc_rise lands on the frame_done cycle.
  - Tick is dropped and ovf_rtc = 1.
  - rtc rise one cycle later is accepted → new latch.
